// File: rtl/hilo_seq_muldiv.sv
// hilo_seq_muldiv
// Multi-cycle MIPS multiply/divide unit that owns the architectural HI/LO
// pair. MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring
// divider. Both run STEPS_PER_CYCLE iterations per clock. MFHI/MFLO reads
// are served through a registered handshake. A read that arrives while an
// operation is in flight is held off with rd_stall.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start, op          launch MULT(00)/MULTU(01)/DIV(10)/DIVU(11) when idle
//   in_1, in_2         rs / rt operands
//   mt_en/mt_sel/mt_data  MTLO (sel=0) / MTHI (sel=1) write, idle only
//   rd_req, rd_sel     MFLO (sel=0) / MFHI (sel=1) request, held until rd_valid
//   rd_data, rd_valid  registered read data and its one-cycle strobe
//   rd_stall           rd_req & busy, pipeline interlock
//   busy               operation in progress
//   div_zero           sticky divide-by-zero flag, cleared by the next start
//   hi, lo             architectural HI/LO
//
// Optional feature: define HILO_ABORT_EN to add an `abort` input. When abort
// is high while busy, the FSM returns to IDLE without touching HI/LO or
// div_zero.
module hilo_seq_muldiv #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef HILO_ABORT_EN
  input  logic        abort,
`endif
  input  logic [1:0]  op,
  input  logic [31:0] in_1,
  input  logic [31:0] in_2,
  input  logic        mt_en,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_stall,
  output logic        busy,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int NCYC = 32 / STEPS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic        is_div, neg_q, neg_r, dvz;
  logic [31:0] in1_raw, opnd, acc, low;
  logic [31:0] acc_step, low_step;
  logic [32:0] rem_try, sum, diff;
  logic [31:0] res_hi, res_lo;
  logic [63:0] prod;
  logic        start_ok, mt_ok, abort_hit, fix_wr;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign busy     = (state != IDLE);
  assign rd_stall = rd_req & busy;
  assign start_ok = start & ~busy;
  assign mt_ok    = mt_en & ~busy & ~start;

`ifdef HILO_ABORT_EN
  assign abort_hit = abort & busy;
`else
  assign abort_hit = 1'b0;
`endif

  // An abort that lands in FIX must also suppress the HI/LO write.
  assign fix_wr = (state == FIX) & ~abort_hit;

  // Signed ops work on magnitudes. Unsigned ops never see a negative sign.
  assign a_neg = ~op[0] & in_1[31];
  assign b_neg = ~op[0] & in_2[31];
  assign a_mag = a_neg ? -in_1 : in_1;
  assign b_mag = b_neg ? -in_2 : in_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 6'd0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // acc/low form one 64-bit working pair. For multiply, low holds the
  // multiplier, which shifts out while product bits shift in. For divide,
  // low holds the dividend, which shifts into acc while quotient bits fill in.
  always_comb begin
    acc_step = acc;
    low_step = low;
    rem_try  = '0;
    sum      = '0;
    diff     = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (is_div) begin
        rem_try = {acc_step, low_step[31]};
        diff    = rem_try - {1'b0, opnd};
        if (rem_try >= {1'b0, opnd}) begin
          acc_step = diff[31:0];
          low_step = {low_step[30:0], 1'b1};
        end else begin
          acc_step = rem_try[31:0];
          low_step = {low_step[30:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, acc_step} + (low_step[0] ? {1'b0, opnd} : 33'd0);
        low_step = {sum[0], low_step[31:1]};
        acc_step = sum[32:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dvz     <= 1'b0;
      in1_raw <= '0;
      opnd    <= '0;
      acc     <= '0;
      low     <= '0;
    end else if (start_ok) begin
      cnt     <= 6'(NCYC - 1);
      is_div  <= op[1];
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      dvz     <= (in_2 == 32'd0);
      in1_raw <= in_1;
      opnd    <= op[1] ? b_mag : a_mag;
      acc     <= '0;
      low     <= op[1] ? a_mag : b_mag;
    end else if (state == CALC) begin
      cnt <= cnt - 6'd1;
      acc <= acc_step;
      low <= low_step;
    end
  end

  // Sign fix-up. A zero divisor bypasses the divider result entirely.
  always_comb begin
    prod = {acc, low};
    if (neg_q) prod = -prod;
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (dvz) begin
      res_hi = in1_raw;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = neg_r ? -acc : acc;
      res_lo = neg_q ? -low : low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_ok) begin
      if (mt_sel) hi <= mt_data;
      else        lo <= mt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      div_zero <= 1'b0;
    else if (start_ok)               div_zero <= 1'b0;
    else if (fix_wr && is_div && dvz) div_zero <= 1'b1;
  end

  // Reads capture HI/LO as they stood before the edge. This means a
  // simultaneous MT write is not visible yet, while a result written in
  // FIX is already visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req & ~busy;
      if (rd_req && !busy) rd_data <= rd_sel ? hi : lo;
    end
  end

endmodule

// File: tb/tb_hilo_seq_muldiv.sv
// tb_hilo_seq_muldiv
// Directed test for hilo_seq_muldiv. The expected values are computed by hand
// from MIPS HI/LO semantics. When HILO_ABORT_EN is defined, the abort port is
// connected and also tested.
module tb_hilo_seq_muldiv;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [31:0] in_1, in_2, mt_data;
  logic        mt_en, mt_sel, rd_req, rd_sel;
  logic [31:0] rd_data, hi, lo;
  logic        rd_valid, rd_stall, busy, div_zero;
`ifdef HILO_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  hilo_seq_muldiv #(.STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef HILO_ABORT_EN
    .abort(abort),
`endif
    .op(op), .in_1(in_1), .in_2(in_2),
    .mt_en(mt_en), .mt_sel(mt_sel), .mt_data(mt_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_stall(rd_stall), .busy(busy),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called on a falling edge: pulse start for one cycle and return on the
  // next falling edge, which is just after the accepting rising edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in_1  = a;
    in_2  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Count falling edges that see busy high, with a bound on the wait.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; in_1 = '0; in_2 = '0;
    mt_en = 1'b0; mt_sel = 1'b0; mt_data = '0; rd_req = 1'b0; rd_sel = 1'b0;
`ifdef HILO_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_rd_data", rd_data, 32'h0);
    checkOutput("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_div_zero", {31'b0, div_zero}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max x max, latency check
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(n);
    checkOutput("multu_busy_cycles", n, 33);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    // MFHI issued one cycle after the start of MULTU 2x3 stalls until done
    applyStimulus(MULTU, 32'd2, 32'd3);
    rd_req = 1'b1;
    rd_sel = 1'b1;
    #1;
    checkOutput("stall_rd_valid_low", {31'b0, rd_valid}, 32'h0);
    n = 0;
    while (rd_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("stall_cycles", n, 33);
    checkOutput("stall_no_valid_yet", {31'b0, rd_valid}, 32'h0);
    @(negedge clk);
    checkOutput("stall_rd_valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("stall_rd_data", rd_data, 32'h0);
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput("stall_valid_pulse", {31'b0, rd_valid}, 32'h0);
    checkOutput("multu23_lo", lo, 32'd6);

    // MULT -3 x 7
    applyStimulus(MULT, 32'hFFFF_FFFD, 32'd7);
    waitDone(n);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFEB);

    // DIV -7 / 2
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone(n);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 0
    applyStimulus(DIVU, 32'd100, 32'd0);
    waitDone(n);
    checkOutput("divz_busy_cycles", n, 33);
    checkOutput("divz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("divz_hi", hi, 32'd100);
    checkOutput("divz_flag", {31'b0, div_zero}, 32'h1);

    // DIVU 9 / 3 clears div_zero at start
    applyStimulus(DIVU, 32'd9, 32'd3);
    checkOutput("divz_cleared_at_start", {31'b0, div_zero}, 32'h0);
    waitDone(n);
    checkOutput("divu_lo", lo, 32'd3);
    checkOutput("divu_hi", hi, 32'd0);

    // Signed overflow 0x8000_0000 / -1
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(n);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'h0);

    // Signed divide by zero keeps the raw dividend in HI
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd0);
    waitDone(n);
    checkOutput("sdivz_lo", lo, 32'hFFFF_FFFF);
    checkOutput("sdivz_hi", hi, 32'hFFFF_FFF9);
    checkOutput("sdivz_flag", {31'b0, div_zero}, 32'h1);

    // MTLO with a simultaneous MFLO, then a back-to-back MFLO
    mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_1234;
    rd_req = 1'b1; rd_sel = 1'b0;
    @(negedge clk);
    mt_en = 1'b0;
    checkOutput("mt_rd_valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("mt_rd_old", rd_data, 32'hFFFF_FFFF);
    checkOutput("mtlo_lo", lo, 32'h0000_1234);
    @(negedge clk);
    checkOutput("b2b_rd_valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("b2b_rd_new", rd_data, 32'h0000_1234);
    rd_req = 1'b0;

    // MTHI together with start, then MTHI plus a second start while busy
    start = 1'b1; op = DIVU; in_1 = 32'd10; in_2 = 32'd3;
    mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; mt_en = 1'b0;
    checkOutput("mt_with_start_hi", hi, 32'hFFFF_FFF9);
    repeat (3) @(negedge clk);
    mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'h0000_BEEF;
    start = 1'b1; op = MULTU; in_1 = 32'd5; in_2 = 32'd5;
    @(negedge clk);
    start = 1'b0; mt_en = 1'b0;
    checkOutput("mt_busy_hi", hi, 32'hFFFF_FFF9);
    checkOutput("mt_busy_busy", {31'b0, busy}, 32'h1);
    waitDone(n);
    checkOutput("start_busy_ignored", n, 29);
    checkOutput("divu10_hi", hi, 32'd1);
    checkOutput("divu10_lo", lo, 32'd3);

    // Reset in the middle of a DIVU
    applyStimulus(DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_mid_hi", hi, 32'h0);
    checkOutput("rst_mid_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef HILO_ABORT_EN
    applyStimulus(MULTU, 32'd7, 32'd6);
    waitDone(n);
    checkOutput("pre_abort_lo", lo, 32'd42);
    applyStimulus(DIVU, 32'd100, 32'd0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    checkOutput("abort_lo", lo, 32'd42);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_div_zero", {31'b0, div_zero}, 32'h0);
    abort = 1'b1;
    applyStimulus(MULTU, 32'd3, 32'd3);
    abort = 1'b0;
    waitDone(n);
    checkOutput("abort_idle_cycles", n, 33);
    checkOutput("abort_idle_lo", lo, 32'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_seq_muldiv.md
Name: hilo_seq_muldiv

Overview:
- Multi-cycle MIPS multiply/divide unit that owns the HI/LO pair and serves the read side: MFHI/MFLO requests from the decode/execute stage.
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from execute.
- Computes iteratively (shift-add / restoring divide) and interlocks MFHI/MFLO reads with a stall while an operation is in flight.

Parameters:
- STEPS_PER_CYCLE, 1, iterations per clock (1 or 2); sets latency.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation `op`; accepted only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- in_1  in  32  rs value (multiplicand / dividend)
- in_2  in  32  rt value (multiplier / divisor)
- mt_en  in  1  move-to write
- mt_sel  in  1  0 = LO (MTLO), 1 = HI (MTHI)
- mt_data  in  32  value for MTHI/MTLO
- rd_req  in  1  MFHI/MFLO request; held until rd_valid
- rd_sel  in  1  0 = LO, 1 = HI
- rd_data  out  32  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_stall  out  1  combinational, rd_req & busy; stalls the pipeline
- busy  out  1  operation in progress
- div_zero  out  1  sticky; set by DIV/DIVU with in_2=0, cleared by the next accepted start
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset value of every output is 0: hi, lo, rd_data, rd_valid, busy, div_zero. State = IDLE. Reset mid-operation aborts it immediately.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1: latch |in_1|, |in_2| (magnitudes for signed ops, raw for unsigned) and the result signs. Go to CALC. busy=1 from the next cycle.
- CALC runs N = 32/STEPS_PER_CYCLE cycles, with one (or two) iterations per cycle.
  - MUL: 64-bit shift-add.
  - DIV: restoring divide, producing a 32-bit quotient and remainder.
- FIX runs one cycle:
  - Apply signs. Product sign = sign(in_1) ^ sign(in_2). Quotient sign = same. Remainder sign = sign(in_1).
  - Write HI/LO at the end of FIX. busy drops the following cycle.
- Latency, start to busy low: STEPS_PER_CYCLE=1 gives 34 cycles (1 + 32 + 1). STEPS_PER_CYCLE=2 gives 18 cycles.
- MUL result: HI = product[63:32], LO = product[31:0].
- DIV result: LO = quotient, HI = remainder.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = in_1 (unsigned bit pattern), div_zero=1. Latency is unchanged.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- start while busy: ignored, no effect.
- mt_en when busy=0 and start=0: the selected register takes mt_data at the clock edge.
- mt_en while busy, or in the same cycle as an accepted start: ignored.
- Read handshake:
  - rd_req sampled with busy=0 means accepted. Next cycle: rd_valid=1, rd_data = selected register value as it was before that edge.
  - A read accepted in the same cycle as mt_en returns the old value.
  - While busy, rd_stall=1, no accept, rd_valid=0.
  - A read accepted in the cycle busy falls returns the new result.
- Back-to-back reads are accepted every cycle.
- hi/lo outputs always reflect the architectural registers.

Optional Feature:
- Macro: HILO_ABORT_EN.
- Defined: adds input port `abort` (1 bit). abort=1 while busy returns the FSM to IDLE next cycle. HI, LO and div_zero stay unchanged. abort in IDLE is ignored. An accepted start in the same cycle as abort starts normally.
- Undefined: no `abort` port. Every accepted operation runs to completion.

Test Plan:
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> after 34 cycles HI=0xFFFF_FFFE, LO=0x0000_0001; busy high exactly 33 cycles.
- MULT −3 × 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. Then DIV −7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 100 / 0 -> LO=0xFFFF_FFFF, HI=100, div_zero=1. Next start (DIVU 9/3) clears div_zero; result LO=3, HI=0.
- rd_req (rd_sel=1) issued 1 cycle after start of MULTU 2×3 -> rd_stall=1 for 33 cycles; then rd_valid pulses once with rd_data=0 (HI).
- MTLO 0x1234 with a simultaneous MFLO read -> rd_data=old LO. Next MFLO -> 0x1234. MTHI during busy leaves HI unchanged.
- rst_n low at cycle 10 of DIVU -> busy=0, hi=lo=0 immediately. With HILO_ABORT_EN, abort at cycle 5 keeps the prior HI/LO.
